alu_seq: RTL and testbench

//  Parametrised, handshaked execute-stage ALU; successor to the single-cycle combinational ALU.
//  - Adds shifts, logic ops, set-less-than and a registered result with valid/ready flow control.
//  - Optionally adds an iterative multiplier.
//  - Sits between decode/operand-fetch and writeback; stalls upstream while busy or while the result is unconsumed.

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with a registered result and valid/ready flow control.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (code 10) and the BUSY state.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_func,
    input  logic [WIDTH-1:0]   alu_src1,
    input  logic [WIDTH-1:0]   alu_src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_result,
    output logic               alu_zero,
    output logic               alu_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
        S_BUSY = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH:0]     calc_s;
    logic               accept_s;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_nx_s;
`endif

    // Single-cycle operations; returns {ovf, result}. Illegal codes yield zero.
    function automatic logic [WIDTH:0] alu_calc(
        input logic [3:0]         func,
        input logic [WIDTH-1:0]   a,
        input logic [WIDTH-1:0]   b,
        input logic [SHAMT_W-1:0] sh
    );
        logic [WIDTH-1:0] r;
        logic             v;
        r = {WIDTH{1'b0}};
        v = 1'b0;
        case (func)
            4'd0: begin
                r = a + b;
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                r = a - b;
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    r = b << sh;
            4'd3:    r = b >> sh;
            4'd4:    r = $signed(b) >>> sh;
            4'd5:    r = a & b;
            4'd6:    r = a | b;
            4'd7:    r = a ^ b;
            4'd8:    r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:    r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: begin
                r = {WIDTH{1'b0}};
                v = 1'b0;
            end
        endcase
        return {v, r};
    endfunction

    assign out_valid  = (state_q == S_DONE);
    assign alu_result = result_q;
    assign alu_zero   = zero_q;
    assign alu_ovf    = ovf_q;
    assign accept_s   = in_valid && in_ready;
    assign calc_s     = alu_calc(alu_func, alu_src1, alu_src2, shamt);

    always_comb begin
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Next state: new results are captured only at accept, or when the multiplier finishes.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_nx_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
        if (accept_s) begin
`ifdef ALU_MUL_EN
            if (alu_func == 4'd10) begin
                state_d  = S_BUSY;
                mcand_d  = alu_src1;
                mplier_d = alu_src2;
                acc_d    = {WIDTH{1'b0}};
                cnt_d    = {SHAMT_W{1'b0}};
            end else begin
                state_d  = S_DONE;
                result_d = calc_s[WIDTH-1:0];
                zero_d   = (calc_s[WIDTH-1:0] == {WIDTH{1'b0}});
                ovf_d    = calc_s[WIDTH];
            end
`else
            state_d  = S_DONE;
            result_d = calc_s[WIDTH-1:0];
            zero_d   = (calc_s[WIDTH-1:0] == {WIDTH{1'b0}});
            ovf_d    = calc_s[WIDTH];
`endif
        end else begin
            case (state_q)
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                    else           state_d = S_DONE;
                end
`ifdef ALU_MUL_EN
                S_BUSY: begin
                    acc_d    = acc_nx_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + {{(SHAMT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        result_d = acc_nx_s;
                        zero_d   = (acc_nx_s == {WIDTH{1'b0}});
                        ovf_d    = 1'b0;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // State and result registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {SHAMT_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); MUL checks follow ALU_MUL_EN.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_func = 4'd0;
    logic [31:0] alu_src1 = 32'd0;
    logic [31:0] alu_src2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_func(alu_func), .alu_src1(alu_src1), .alu_src2(alu_src2), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with in_ready high; checks the result one edge later.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_r, input logic exp_z, input logic exp_v);
        in_valid = 1'b1; alu_func = f; alu_src1 = a; alu_src2 = b; shamt = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_val({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk_val({tag, ".res"}, alu_result, exp_r);
        chk_val({tag, ".zero"}, {31'd0, alu_zero}, {31'd0, exp_z});
        chk_val({tag, ".ovf"}, {31'd0, alu_ovf}, {31'd0, exp_v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic busy_ok;

        #2;
        chk_val("rst.valid", {31'd0, out_valid}, 32'd0);
        chk_val("rst.res", alu_result, 32'd0);
        chk_val("rst.zero", {31'd0, alu_zero}, 32'd0);
        chk_val("rst.ovf", {31'd0, alu_ovf}, 32'd0);
        chk_val("rst.in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back, one result per cycle
        run_op("b2b.add", 4'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0);
        run_op("b2b.sub", 4'd1, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("b2b.xor", 4'd7, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 1'b0);

        // flags and shifts
        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0);
        run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("sra", 4'd4, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
        run_op("srl", 4'd3, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
        run_op("and", 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1'b0);
        run_op("or", 4'd6, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01, 1'b0, 1'b0);

        // compare and illegal
        run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0);
        run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0);
        run_op("illegal", 4'd15, 32'h1234_5678, 32'h1, 5'd3, 32'd0, 1'b1, 1'b0);

        // backpressure: SLL result must hold while the consumer stalls
        @(posedge clk); #1;
        chk_val("bp.idle", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_func = 4'd2; alu_src1 = 32'd0; alu_src2 = 32'd1; shamt = 5'd31;
        @(posedge clk); #1;
        alu_func = 4'd0; alu_src1 = 32'd1; alu_src2 = 32'd1; shamt = 5'd0;
        for (int i = 0; i < 4; i++) begin
            chk_val("bp.valid", {31'd0, out_valid}, 32'd1);
            chk_val("bp.res", alu_result, 32'h8000_0000);
            chk_val("bp.in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk_val("bp.release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_val("bp.next_res", alu_result, 32'd2);
        chk_val("bp.next_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk_val("bp.drain", {31'd0, out_valid}, 32'd0);

`ifdef ALU_MUL_EN
        // multiply: WIDTH+1 cycle latency, stalled upstream while busy
        in_valid = 1'b1; alu_func = 4'd10; alu_src1 = 32'd1234; alu_src2 = 32'd5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk_val("mul.latency", cyc, 32'd33);
        chk_val("mul.busy_ready", {31'd0, busy_ok}, 32'd1);
        chk_val("mul.res", alu_result, 32'd7006652);
        chk_val("mul.ovf", {31'd0, alu_ovf}, 32'd0);
        @(posedge clk); #1;

        // reset in the middle of a multiply
        in_valid = 1'b1; alu_func = 4'd10; alu_src1 = 32'd99; alu_src2 = 32'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_val("rstmul.valid", {31'd0, out_valid}, 32'd0);
        chk_val("rstmul.res", alu_result, 32'd0);
        chk_val("rstmul.in_ready", {31'd0, in_ready}, 32'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("rstmul.add", 4'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0);
`else
        cyc = 0;
        busy_ok = 1'b1;
        run_op("mul_off", 4'd10, 32'd1234, 32'd5678, 5'd0, 32'd0, 1'b1, 1'b0);
        chk_val("mul_off.in_ready", {31'd0, in_ready}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
